// File: rtl/c_bus_arbiter.sv
// Round-robin arbiter for the 4-bit C-operand path: two requesters share one C-select mux.
// A per-owner burst limit bounds how long one side can hold the path; all outputs are registered.
module c_bus_arbiter #(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Req0,
  input  logic [WIDTH-1:0] Data0,
  input  logic             Req1,
  input  logic [WIDTH-1:0] Data1,
  input  logic             Ready,
  output logic             Gnt0,
  output logic             Gnt1,
  output logic             S_C,
  output logic [WIDTH-1:0] Out_C,
  output logic             Valid_C,
  output logic             Busy
);

  localparam int CW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    count, count_next;
  logic             last_served, last_next;
  logic [WIDTH-1:0] out_next;
  logic             valid_next;
  logic             own, req_own, req_oth, xfer, limit_hit;

  always_comb begin
    state_next = state;
    count_next = count;
    last_next  = last_served;
    out_next   = Out_C;
    valid_next = 1'b0;
    xfer       = 1'b0;
    limit_hit  = 1'b0;
    own        = (state == GRANT1);
    req_own    = own ? Req1 : Req0;
    req_oth    = own ? Req0 : Req1;

    case (state)
      IDLE: begin
        if (Req0 && Req1)
          state_next = last_served ? GRANT0 : GRANT1;
        else if (Req0)
          state_next = GRANT0;
        else if (Req1)
          state_next = GRANT1;
      end
      GRANT0, GRANT1: begin
        xfer = req_own && Ready;
        if (xfer) begin
          out_next   = own ? Data1 : Data0;
          valid_next = 1'b1;
          // Saturate so the unlimited mode (MAX_BURST==0) can never wrap.
          if (count != '1)
            count_next = count + 1'b1;
        end
        limit_hit = (MAX_BURST != 0) && xfer && (count_next == CW'(MAX_BURST));
        if (!req_own || limit_hit) begin
          last_next  = own;
          count_next = '0;
          if (req_oth)
            state_next = own ? GRANT0 : GRANT1;
          else if (req_own)
            state_next = state;
          else
            state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      count       <= '0;
      last_served <= 1'b1;
      Out_C       <= '0;
      Valid_C     <= 1'b0;
      Gnt0        <= 1'b0;
      Gnt1        <= 1'b0;
      S_C         <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      last_served <= last_next;
      Out_C       <= out_next;
      Valid_C     <= valid_next;
      Gnt0        <= (state_next == GRANT0);
      Gnt1        <= (state_next == GRANT1);
      S_C         <= (state_next == GRANT1);
      Busy        <= (state_next != IDLE);
    end
  end

endmodule
